spa_rbs_unwind: RTL and testbench

Parametrised register-backup-stack (RBS) and RNUM controller for the DPM scratchpad address path, successor to the fixed six-entry RBS in the SPA. Records every auto-increment/decrement GPR reference (direction, data size, register number) and supports configurable depth. Adds overflow/underflow detection and a hardware unwind sequencer. On a fault, the unwind sequencer walks the stack newest-first and issues one GPR-correction request per entry over a req/ack handshake, so microcode no longer pops the stack entry by entry.

---
 rtl/spa_rbs_unwind.sv | 105 ++++++++++
 tb/tb_spa_rbs_unwind.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/spa_rbs_unwind.sv
// spa_rbs_unwind: parametrised register-backup stack with RNUM control and a hardware unwind sequencer
module spa_rbs_unwind #(
  parameter int DEPTH = 6,
  parameter int RNUM_W = 4,
  parameter int DSIZE_W = 2,
  parameter int DELTA_W = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               m_clk_l,
  input  logic               reset_l,
  input  logic               d_clk_en_h,
  input  logic               push_h,
  input  logic               push_add_h,
  input  logic [DSIZE_W-1:0] dsize_h,
  input  logic               ird_ld_rnum_h,
  input  logic [RNUM_W-1:0]  ird_rnum_h,
  input  logic               wb_ld_rnum_h,
  input  logic [RNUM_W-1:0]  wbus_in_h,
  input  logic               read_rbs_h,
  input  logic               zero_rbs_h,
  input  logic               unw_start_h,
  input  logic               unw_ack_h,
  output logic [RNUM_W-1:0]  rnum_h,
  output logic [CNT_W-1:0]   rbs_cnt_h,
  output logic               rbs_full_h,
  output logic               rbs_empty_h,
  output logic               rbs_ovf_h,
  output logic               rbs_unf_h,
  output logic               unw_req_h,
  output logic [RNUM_W-1:0]  unw_rnum_h,
  output logic [DELTA_W-1:0] unw_delta_h,
  output logic               unw_busy_h,
  output logic               unw_done_h
);
  localparam int IW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d, base;
  logic [RNUM_W-1:0] rnum, rnum_d;
  logic ovf, ovf_d, unf, unf_d;
  logic add_q [DEPTH];
  logic [DSIZE_W-1:0] dsize_q [DEPTH];
  logic [RNUM_W-1:0] rnum_q [DEPTH];
  logic [IW-1:0] top, wr;
  logic idle, pop, unf_set, push_ok, ovf_set, upop;
  logic [DELTA_W-1:0] mag;
  always_comb begin
    idle = state == IDLE;
    top = IW'(cnt - 1'b1);
    pop = idle && read_rbs_h && cnt != '0 && !zero_rbs_h;
    unf_set = idle && read_rbs_h && cnt == '0 && !zero_rbs_h;
    base = pop ? cnt - 1'b1 : cnt;
    wr = IW'(base);
    push_ok = idle && push_h && !zero_rbs_h && base != CNT_W'(DEPTH);
    ovf_set = idle && push_h && !zero_rbs_h && base == CNT_W'(DEPTH);
    upop = state == REQ && unw_ack_h && !zero_rbs_h;
    cnt_d = zero_rbs_h ? '0 : upop ? cnt - 1'b1 : base + CNT_W'(push_ok);
    rnum_d = ird_ld_rnum_h ? ird_rnum_h : wb_ld_rnum_h ? wbus_in_h : pop ? rnum_q[top] : rnum;
    ovf_d = !zero_rbs_h && (ovf || ovf_set);
    unf_d = !zero_rbs_h && (unf || unf_set);
    state_d = state;
    case (state)
      IDLE: if (unw_start_h && !zero_rbs_h) state_d = cnt != '0 ? REQ : DONE;
      REQ: if (zero_rbs_h) state_d = IDLE; else if (unw_ack_h && cnt == CNT_W'(1)) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge m_clk_l or negedge reset_l) begin
    if (!reset_l) begin
      state <= IDLE;
      cnt <= '0;
      rnum <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else if (d_clk_en_h) begin
      state <= state_d;
      cnt <= cnt_d;
      rnum <= rnum_d;
      ovf <= ovf_d;
      unf <= unf_d;
    end
  end
  // the pushed entry captures RNUM as it was before any same-cycle load
  always_ff @(posedge m_clk_l) begin
    if (d_clk_en_h && push_ok) begin
      add_q[wr] <= push_add_h;
      dsize_q[wr] <= dsize_h;
      rnum_q[wr] <= rnum;
    end
  end
  always_comb begin
    mag = DELTA_W'(1) << dsize_q[top];
    unw_req_h = state == REQ;
    unw_rnum_h = unw_req_h ? rnum_q[top] : '0;
    unw_delta_h = !unw_req_h ? '0 : add_q[top] ? -mag : mag;
    unw_busy_h = !idle;
    unw_done_h = state == DONE;
    rnum_h = rnum;
    rbs_cnt_h = cnt;
    rbs_full_h = cnt == CNT_W'(DEPTH);
    rbs_empty_h = cnt == '0;
    rbs_ovf_h = ovf;
    rbs_unf_h = unf;
  end
endmodule

// File: tb/tb_spa_rbs_unwind.sv
// tb_spa_rbs_unwind: directed self-checking bench for spa_rbs_unwind
module tb_spa_rbs_unwind;
  logic clk = 0, reset_l = 0, en = 1, push = 0, padd = 0, ird_ld = 0, wb_ld = 0, rd = 0, zero = 0, start = 0, ack = 0;
  logic [1:0] dsize = 0;
  logic [3:0] ird_rnum = 0, wbus = 0, rnum, urnum;
  logic [2:0] cnt;
  logic full, empty, ovf, unf, req, busy, done;
  logic [7:0] delta;
  int tests = 0, fails = 0;
  spa_rbs_unwind dut (
    .m_clk_l(clk), .reset_l(reset_l), .d_clk_en_h(en), .push_h(push), .push_add_h(padd), .dsize_h(dsize),
    .ird_ld_rnum_h(ird_ld), .ird_rnum_h(ird_rnum), .wb_ld_rnum_h(wb_ld), .wbus_in_h(wbus), .read_rbs_h(rd),
    .zero_rbs_h(zero), .unw_start_h(start), .unw_ack_h(ack), .rnum_h(rnum), .rbs_cnt_h(cnt), .rbs_full_h(full),
    .rbs_empty_h(empty), .rbs_ovf_h(ovf), .rbs_unf_h(unf), .unw_req_h(req), .unw_rnum_h(urnum),
    .unw_delta_h(delta), .unw_busy_h(busy), .unw_done_h(done)
  );
  always #5 clk = ~clk;
  task tick;
    @(posedge clk);
    #1;
  endtask
  task load(input logic [3:0] v);
    wb_ld = 1; wbus = v; tick; wb_ld = 0;
  endtask
  task push_e(input logic a, input logic [1:0] d);
    push = 1; padd = a; dsize = d; tick; push = 0;
  endtask
  task test_reset;
    reset_l = 0; #1;
    tests++;
    if ({rnum, cnt, empty, full, ovf, unf, req, busy, done, urnum, delta} !== {4'd0, 3'd0, 1'b1, 6'b0, 4'd0, 8'd0}) begin
      fails++; $display("FAIL reset got %h want %h", {rnum, cnt, empty, full, ovf, unf, req, busy, done, urnum, delta}, {4'd0, 3'd0, 1'b1, 6'b0, 4'd0, 8'd0});
    end
    tick; reset_l = 1; tick;
  endtask
  task test_flags;
    for (int i = 0; i < 6; i++) push_e(0, 0);
    tests++;
    if ({cnt, full, empty, ovf} !== {3'd6, 3'b100}) begin fails++; $display("FAIL full got %b want %b", {cnt, full, empty, ovf}, {3'd6, 3'b100}); end
    push_e(1, 1);
    tests++;
    if ({cnt, full, ovf} !== {3'd6, 2'b11}) begin fails++; $display("FAIL ovf got %b want %b", {cnt, full, ovf}, {3'd6, 2'b11}); end
    zero = 1; tick; zero = 0;
    tests++;
    if ({cnt, empty, ovf} !== {3'd0, 2'b10}) begin fails++; $display("FAIL zero got %b want %b", {cnt, empty, ovf}, {3'd0, 2'b10}); end
  endtask
  task test_push_pop;
    load(5); push_e(1, 1); load(9); push_e(0, 0);
    rd = 1; tick;
    tests++;
    if ({rnum, cnt} !== {4'd9, 3'd1}) begin fails++; $display("FAIL pop1 got %h want %h", {rnum, cnt}, {4'd9, 3'd1}); end
    tick;
    tests++;
    if ({rnum, cnt} !== {4'd5, 3'd0}) begin fails++; $display("FAIL pop2 got %h want %h", {rnum, cnt}, {4'd5, 3'd0}); end
    tick; rd = 0;
    tests++;
    if ({rnum, cnt, unf} !== {4'd5, 3'd0, 1'b1}) begin fails++; $display("FAIL unf got %h want %h", {rnum, cnt, unf}, {4'd5, 3'd0, 1'b1}); end
    zero = 1; tick; zero = 0;
    tests++;
    if (unf !== 1'b0) begin fails++; $display("FAIL unf_clr got %b want 0", unf); end
  endtask
  task test_push_read_same;
    load(6); push_e(0, 0); load(8);
    push = 1; rd = 1; tick; push = 0; rd = 0;
    tests++;
    if ({rnum, cnt} !== {4'd6, 3'd1}) begin fails++; $display("FAIL pushpop got %h want %h", {rnum, cnt}, {4'd6, 3'd1}); end
    rd = 1; tick; rd = 0;
    tests++;
    if ({rnum, cnt} !== {4'd8, 3'd0}) begin fails++; $display("FAIL replaced got %h want %h", {rnum, cnt}, {4'd8, 3'd0}); end
  endtask
  task test_unwind;
    load(3); push_e(1, 2); load(7); push_e(0, 0);
    start = 1; tick; start = 0;
    for (int i = 0; i < 4; i++) begin
      tests++;
      if ({req, busy, urnum, delta, cnt} !== {2'b11, 4'd7, 8'h01, 3'd2}) begin fails++; $display("FAIL stall%0d got %h want %h", i, {req, busy, urnum, delta, cnt}, {2'b11, 4'd7, 8'h01, 3'd2}); end
      if (i < 3) tick;
    end
    ack = 1; tick;
    tests++;
    if ({req, urnum, delta, cnt} !== {1'b1, 4'd3, 8'hFC, 3'd1}) begin fails++; $display("FAIL unw2 got %h want %h", {req, urnum, delta, cnt}, {1'b1, 4'd3, 8'hFC, 3'd1}); end
    tick; ack = 0;
    tests++;
    if ({req, done, cnt, urnum, delta} !== {2'b01, 3'd0, 4'd0, 8'd0}) begin fails++; $display("FAIL unw_done got %h want %h", {req, done, cnt, urnum, delta}, {2'b01, 3'd0, 4'd0, 8'd0}); end
    tick;
    tests++;
    if ({done, busy} !== 2'b00) begin fails++; $display("FAIL unw_idle got %b want 00", {done, busy}); end
  endtask
  task test_back_to_back;
    load(1); push_e(0, 1); load(2); push_e(1, 0); load(3); push_e(0, 3);
    start = 1; tick; start = 0; ack = 1;
    tests++;
    if ({req, urnum, delta} !== {1'b1, 4'd3, 8'h08}) begin fails++; $display("FAIL b2b0 got %h want %h", {req, urnum, delta}, {1'b1, 4'd3, 8'h08}); end
    tick;
    tests++;
    if ({req, urnum, delta} !== {1'b1, 4'd2, 8'hFF}) begin fails++; $display("FAIL b2b1 got %h want %h", {req, urnum, delta}, {1'b1, 4'd2, 8'hFF}); end
    tick;
    tests++;
    if ({req, urnum, delta} !== {1'b1, 4'd1, 8'h02}) begin fails++; $display("FAIL b2b2 got %h want %h", {req, urnum, delta}, {1'b1, 4'd1, 8'h02}); end
    tick; ack = 0;
    tests++;
    if ({req, done, cnt} !== {2'b01, 3'd0}) begin fails++; $display("FAIL b2b_done got %b want %b", {req, done, cnt}, {2'b01, 3'd0}); end
    tick;
  endtask
  task test_empty_abort;
    start = 1; tick; start = 0;
    tests++;
    if ({req, done, busy} !== 3'b011) begin fails++; $display("FAIL empty_unw got %b want 011", {req, done, busy}); end
    tick;
    tests++;
    if ({req, done, busy} !== 3'b000) begin fails++; $display("FAIL empty_end got %b want 000", {req, done, busy}); end
    push_e(0, 0); push_e(0, 0);
    start = 1; tick; start = 0;
    zero = 1; tick; zero = 0;
    tests++;
    if ({req, done, busy, cnt} !== {3'b000, 3'd0}) begin fails++; $display("FAIL abort got %b want %b", {req, done, busy, cnt}, {3'b000, 3'd0}); end
    tick;
    tests++;
    if ({done, busy} !== 2'b00) begin fails++; $display("FAIL abort_nodone got %b want 00", {done, busy}); end
  endtask
  task test_priority;
    load(2); push_e(0, 0); load(4); push_e(0, 0);
    ird_ld = 1; ird_rnum = 11; wb_ld = 1; wbus = 12; rd = 1; tick; ird_ld = 0; wb_ld = 0; rd = 0;
    tests++;
    if ({rnum, cnt} !== {4'd11, 3'd1}) begin fails++; $display("FAIL prio got %h want %h", {rnum, cnt}, {4'd11, 3'd1}); end
    rd = 1; tick; rd = 0;
    tests++;
    if ({rnum, cnt} !== {4'd2, 3'd0}) begin fails++; $display("FAIL prio_pop got %h want %h", {rnum, cnt}, {4'd2, 3'd0}); end
  endtask
  task test_gating;
    push_e(1, 0);
    en = 0; push = 1; tick; push = 0; en = 1;
    tests++;
    if (cnt !== 3'd1) begin fails++; $display("FAIL gate_push got %0d want 1", cnt); end
    start = 1; tick; start = 0;
    en = 0; ack = 1; tick;
    tests++;
    if ({req, cnt, urnum, delta} !== {1'b1, 3'd1, 4'd2, 8'hFF}) begin fails++; $display("FAIL gate_ack got %h want %h", {req, cnt, urnum, delta}, {1'b1, 3'd1, 4'd2, 8'hFF}); end
    en = 1; tick; ack = 0; en = 0; tick;
    tests++;
    if ({done, cnt} !== {1'b1, 3'd0}) begin fails++; $display("FAIL gate_done got %b want %b", {done, cnt}, {1'b1, 3'd0}); end
    en = 1; tick;
    tests++;
    if (done !== 1'b0) begin fails++; $display("FAIL gate_done_fall got %b want 0", done); end
  endtask
  task test_reset_mid;
    load(9); push_e(0, 0); push_e(1, 1);
    start = 1; tick; start = 0;
    tests++;
    if (req !== 1'b1) begin fails++; $display("FAIL mid_req got %b want 1", req); end
    #2; reset_l = 0; #1;
    tests++;
    if ({rnum, cnt, empty, req, busy, done, urnum, delta} !== {4'd0, 3'd0, 4'b1000, 4'd0, 8'd0}) begin fails++; $display("FAIL mid_reset got %h want %h", {rnum, cnt, empty, req, busy, done, urnum, delta}, {4'd0, 3'd0, 4'b1000, 4'd0, 8'd0}); end
    tick; reset_l = 1; tick;
    tests++;
    if ({done, busy, cnt} !== {2'b00, 3'd0}) begin fails++; $display("FAIL post_reset got %b want %b", {done, busy, cnt}, {2'b00, 3'd0}); end
  endtask
  initial begin
    test_reset;
    test_flags;
    test_push_pop;
    test_push_read_same;
    test_unwind;
    test_back_to_back;
    test_empty_abort;
    test_priority;
    test_gating;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
